// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - round-robin arbiter for a shared tristate bus
// Registered grant/select with a one-cycle turnaround between owners and an optional tenure cap.
module bus_arbiter #(
  parameter int NUM_MASTERS = 3,
  parameter int SEL_W       = 2,
  parameter int MAX_HOLD    = 8,
  parameter int HOLD_W      = 4
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [NUM_MASTERS-1:0] req,
  output logic [NUM_MASTERS-1:0] grant,
  output logic [SEL_W-1:0]       sel,
  output logic                   bus_busy,
  output logic                   hold_timeout
);

  localparam int PTR_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  if (NUM_MASTERS > (1 << SEL_W) - 1) begin : g_bad_num_masters
    $error("bus_arbiter: NUM_MASTERS does not fit in SEL_W select codes");
  end
  if (MAX_HOLD > (1 << HOLD_W) - 1) begin : g_bad_max_hold
    $error("bus_arbiter: MAX_HOLD does not fit in HOLD_W");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } state_t;

  state_t                 state_q;
  logic [PTR_W-1:0]       ptr_q;
  logic [PTR_W-1:0]       owner_q;
  logic [HOLD_W-1:0]      cnt_q;
  logic [NUM_MASTERS-1:0] grant_q;
  logic [SEL_W-1:0]       sel_q;
  logic                   busy_q;
  logic                   timeout_q;

  logic                   win_vld_d;
  logic [PTR_W-1:0]       win_idx_d;
  logic [PTR_W-1:0]       ptr_d;
  logic                   owner_req_d;
  logic                   hold_hit_d;

  // Rotating search: first set request at or after ptr_q, wrapping modulo NUM_MASTERS.
  always_comb begin
    int                     idx;
    logic [NUM_MASTERS-1:0] req_sh;
    win_vld_d = 1'b0;
    win_idx_d = '0;
    idx       = 0;
    req_sh    = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NUM_MASTERS) begin
        idx = idx - NUM_MASTERS;
      end
      req_sh = req >> idx;
      if (!win_vld_d && req_sh[0]) begin
        win_vld_d = 1'b1;
        win_idx_d = PTR_W'(idx);
      end
    end
  end

  always_comb begin
    int                     nxt;
    logic [NUM_MASTERS-1:0] own_sh;
    nxt = int'(owner_q) + 1;
    if (nxt >= NUM_MASTERS) begin
      nxt = 0;
    end
    ptr_d       = PTR_W'(nxt);
    own_sh      = req >> owner_q;
    owner_req_d = own_sh[0];
    hold_hit_d  = (MAX_HOLD != 0) && (cnt_q == HOLD_W'(MAX_HOLD));
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      owner_q   <= '0;
      cnt_q     <= '0;
      grant_q   <= '0;
      sel_q     <= '0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        IDLE, TURN: begin
          if (win_vld_d) begin
            grant_q <= NUM_MASTERS'(1) << win_idx_d;
            sel_q   <= SEL_W'(int'(win_idx_d) + 1);
            busy_q  <= 1'b1;
            owner_q <= win_idx_d;
            cnt_q   <= HOLD_W'(1);
            state_q <= GRANT;
          end else begin
            state_q <= IDLE;
          end
        end
        GRANT: begin
          // A drop on the cap cycle counts as voluntary, so no timeout pulse then.
          if (!owner_req_d || hold_hit_d) begin
            grant_q   <= '0;
            sel_q     <= '0;
            busy_q    <= 1'b0;
            ptr_q     <= ptr_d;
            timeout_q <= owner_req_d;
            state_q   <= TURN;
          end else if (cnt_q != '1) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          grant_q <= '0;
          sel_q   <= '0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign grant        = grant_q;
  assign sel          = sel_q;
  assign bus_busy     = busy_q;
  assign hold_timeout = timeout_q;

endmodule
